// File: rtl/fp_norm_pkg.sv
// Shared types and sizing for the FPU add/sub normalization sequencer.
// No logic here: widths, group geometry and the sequencer state encoding only.
// Backpressure: n/a.
package fp_norm_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int GRP_W  = 4;
  localparam int NGRP   = MANT_W / GRP_W;
  localparam int SHC_W  = $clog2(NGRP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COARSE = 2'd1,
    S_FINE   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fp_norm_seq_grp_enc.sv
// Leading all-zero group counter for the coarse normalization step.
// Latency: combinational. Backpressure: n/a.
// Flags arrive MSB group first; the count saturates at N-1 since the last group never shifts out.
module norm_grp_enc
  import fp_norm_pkg::*;
#(
  parameter int N  = NGRP,
  parameter int CW = SHC_W
) (
  input  logic [N-1:0]  i_zflags,
  output logic [CW-1:0] o_cnt
);

  logic w_run;

  always_comb begin
    o_cnt = '0;
    w_run = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      w_run = w_run & i_zflags[i];
      if (w_run && (i != 0)) begin
        o_cnt = o_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_norm_seq.sv
// Normalizer: left-shifts mantissa until MSB set, decrementing exponent, clamping at denormal (FP_NORM_COARSE_EN adds group-skip step).
// Latency: 1 cycle for zero/denormal bypass, 2 (coarse) or 1 (no coarse) plus one per fine shift otherwise.
// Backpressure: single-entry; results held in DONE until o_out_ready, o_in_ready low from accept until handshake.
module fp_norm_seq
  import fp_norm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [MANT_W-1:0] i_mant_in,
  input  logic [EXP_W-1:0]  i_exp_in,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [MANT_W-1:0] o_mant_out,
  output logic [EXP_W-1:0]  o_exp_out,
  output logic              o_zero_out,
  output logic              o_uflow_out
);

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t            r_state;
  logic [MANT_W-1:0] r_m;
  logic [EXP_W-1:0]  r_e;
  logic              r_zero;
  logic              r_byp;

`ifdef FP_NORM_COARSE_EN
  logic [NGRP-1:0]  w_zflags;
  logic [SHC_W-1:0] w_k;
  logic [EXP_W-1:0] w_cshift;

  for (genvar g = 0; g < NGRP; g++) begin : g_zf
    assign w_zflags[g] = ~|r_m[g*GRP_W +: GRP_W];
  end

  norm_grp_enc #(.N(NGRP), .CW(SHC_W)) u_grp_enc (
    .i_zflags (w_zflags),
    .o_cnt    (w_k)
  );

  assign w_cshift = EXP_W'(w_k) * EXP_W'(GRP_W);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_m         <= '0;
      r_e         <= '0;
      r_zero      <= 1'b0;
      r_byp       <= 1'b0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_mant_out  <= '0;
      o_exp_out   <= '0;
      o_zero_out  <= 1'b0;
      o_uflow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_m        <= i_mant_in;
            r_e        <= i_exp_in;
            r_zero     <= 1'b0;
            r_byp      <= 1'b0;
            o_in_ready <= 1'b0;
            // Bypass results take one FINE pass so they still emerge a registered cycle after accept.
            if (i_mant_in == '0) begin
              r_zero  <= 1'b1;
              r_e     <= '0;
              r_byp   <= 1'b1;
              r_state <= S_FINE;
            end else if (i_exp_in == '0) begin
              r_byp   <= 1'b1;
              r_state <= S_FINE;
            end else begin
`ifdef FP_NORM_COARSE_EN
              r_state <= S_COARSE;
`else
              r_state <= S_FINE;
`endif
            end
          end
        end
`ifdef FP_NORM_COARSE_EN
        S_COARSE: begin
          if (r_e > w_cshift) begin
            r_m <= r_m << w_cshift;
            r_e <= r_e - w_cshift;
          end
          r_state <= S_FINE;
        end
`endif
        S_FINE: begin
          if (r_byp || r_m[MANT_W-1]) begin
            o_mant_out  <= r_m;
            o_exp_out   <= r_e;
            o_zero_out  <= r_zero;
            o_uflow_out <= 1'b0;
            o_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_e > EXP_ONE) begin
            r_m <= r_m << 1;
            r_e <= r_e - EXP_ONE;
          end else begin
            // Exponent would hit zero: leave the mantissa denormal rather than shift further.
            r_e         <= '0;
            o_mant_out  <= r_m;
            o_exp_out   <= '0;
            o_zero_out  <= 1'b0;
            o_uflow_out <= 1'b1;
            o_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          o_out_valid <= 1'b0;
          o_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_seq.sv
// Scoreboard bench for fp_norm_seq: driver queues hand-computed results, a negedge monitor checks them.
// Expected latencies depend on whether FP_NORM_COARSE_EN is defined.
`timescale 1ns/1ps
module tb_fp_norm_seq;

`ifdef FP_NORM_COARSE_EN
  localparam bit COARSE = 1'b1;
`else
  localparam bit COARSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] mant_in = '0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] mant_out;
  logic [7:0]  exp_out;
  logic        zero_out;
  logic        uflow_out;

  fp_norm_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_mant_in   (mant_in),
    .i_exp_in    (exp_in),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_mant_out  (mant_out),
    .o_exp_out   (exp_out),
    .o_zero_out  (zero_out),
    .o_uflow_out (uflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        uflow;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: every cycle a result is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else if (out_valid) begin
      check("in_ready_low_while_valid", in_ready, 0);
      if (sbq.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        check("mant_out", mant_out, sbq[0].mant);
        check("exp_out", exp_out, sbq[0].exp);
        check("zero_out", zero_out, sbq[0].zero);
        check("uflow_out", uflow_out, sbq[0].uflow);
        if (!prev_vld) check("latency", cyc - sbq[0].acc - 1, sbq[0].lat);
        if (out_ready) void'(sbq.pop_front());
      end
      prev_vld = !out_ready;
    end else begin
      prev_vld = 1'b0;
    end
  end

  function automatic exp_t mk(input logic [23:0] m, input logic [7:0] e, input logic z, input logic u,
                              input int lc, input int ln, input int acc);
    exp_t x;
    x.mant = m; x.exp = e; x.zero = z; x.uflow = u;
    x.lat = COARSE ? lc : ln;
    x.acc = acc;
    return x;
  endfunction

  task automatic send(input logic [23:0] m, input logic [7:0] e, input logic [23:0] xm, input logic [7:0] xe,
                      input logic xz, input logic xu, input int lc, input int ln);
    int budget = 200;
    @(posedge clk); #1;
    mant_in = m; exp_in = e; in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    sbq.push_back(mk(xm, xe, xz, xu, lc, ln, cyc));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 100;
    while (sbq.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (sbq.size() != 0) begin
      fail_now("drain_timeout");
      sbq.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_mant_out", mant_out, 0);
    check("reset_exp_out", exp_out, 0);
    check("reset_zero_out", zero_out, 0);
    check("reset_uflow_out", uflow_out, 0);
    rst_n = 1'b1;

    //    mant_in    exp   mant_out  exp  z     u     lat(coarse) lat(fine only)
    send(24'h000ABC, 100, 24'hABC000, 88, 1'b0, 1'b0, 2, 13); drain();
    send(24'h012345,  50, 24'h91A280, 43, 1'b0, 1'b0, 5,  8); drain();
    send(24'h000001,   5, 24'h000010,  0, 1'b0, 1'b1, 6,  5); drain();
    send(24'h000000,  77, 24'h000000,  0, 1'b1, 1'b0, 1,  1); drain();
    send(24'h400000,   0, 24'h400000,  0, 1'b0, 1'b0, 1,  1); drain();
    send(24'hFFFFFF,   1, 24'hFFFFFF,  1, 1'b0, 1'b0, 2,  1); drain();
    send(24'h0000F0,   3, 24'h0003C0,  0, 1'b0, 1'b1, 4,  3); drain();
    send(24'h000010,  21, 24'h800000,  2, 1'b0, 1'b0, 5, 20); drain();
    send(24'h0ABCDE,   4, 24'h55E6F0,  0, 1'b0, 1'b1, 5,  4); drain();
    send(24'h0ABCDE,   5, 24'hABCDE0,  1, 1'b0, 1'b0, 2,  5); drain();

    // Backpressure: stall 5 cycles in DONE, then release with the next input already waiting.
    out_ready = 1'b0;
    send(24'h000ABC, 100, 24'hABC000, 88, 1'b0, 1'b0, 2, 13);
    budget = 100;
    while (!out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!out_valid) fail_now("stall_valid_timeout");
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    mant_in = 24'h012345; exp_in = 50; in_valid = 1'b1;
    sbq.push_back(mk(24'h91A280, 43, 1'b0, 1'b0, 5, 8, cyc + 1));
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;
    check("accepted_cycle_after_release", in_ready, 0);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of FINE discards the work.
    send(24'h000001, 100, 24'h800000, 77, 1'b0, 1'b0, 5, 24);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_mant_out", mant_out, 0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(24'h800000, 10, 24'h800000, 10, 1'b0, 1'b0, 2, 1); drain();

    repeat (3) @(posedge clk);
    #1;
    check("idle_after_all", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_seq.md
Name: fp_norm_seq

Overview:
- Multi-cycle normalization sequencer for the FPU add/sub path.
- Sits after the mantissa adder and before rounding.
- Takes an unnormalized mantissa/exponent pair and left-shifts until the MSB is set.
- Uses a coarse group-skip step driven by per-group all-zero flags, then 1-bit fine steps, decrementing the exponent and clamping at the denormal boundary.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, biased exponent width.
- GRP_W, 4, bits per zero-detect group; MANT_W must be a multiple of GRP_W, and NGRP = MANT_W/GRP_W (6).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept.
- mant_in  in  MANT_W  unnormalized mantissa.
- exp_in  in  EXP_W  biased exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- mant_out  out  MANT_W  normalized mantissa.
- exp_out  out  EXP_W  adjusted exponent.
- zero_out  out  1  result is exact zero.
- uflow_out  out  1  normalization clamped to denormal.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - mant_out, exp_out, zero_out and uflow_out all 0.
  - Reset mid-operation aborts the work and the result is discarded.
- States: IDLE, COARSE, FINE, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid, latch mant_in/exp_in into working registers m, e.
  - If m==0: zero_out=1, e=0, go to DONE.
  - Else if exp_in==0: pass through unchanged, go to DONE.
  - Else go to COARSE.
- COARSE (1 cycle):
  - k = count of leading all-zero GRP_W groups, from norm_grp_enc, range 0..NGRP-1.
  - If e > GRP_W*k: m <<= GRP_W*k, e -= GRP_W*k.
  - Else no shift.
  - Then go to FINE.
- FINE:
  - If m[MSB]==1: go to DONE.
  - Else if e>1: m <<= 1, e -= 1, stay in FINE.
  - Else (e==1, MSB 0): e=0, uflow=1, go to DONE.
  - After a successful coarse step this takes at most GRP_W-1 shift cycles; when coarse is skipped it takes up to MANT_W-1.
- DONE:
  - out_valid=1; outputs are registered and held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0 outside IDLE; there is no input/output overlap.
- Latency, from the accept edge to out_valid:
  - 2 cycles when no fine shift is needed.
  - +1 per fine shift.
  - 1 cycle for the zero/denormal-bypass paths.
- Arithmetic:
  - Exponent subtraction is unsigned and never wraps; the guards above guarantee e≥0.
  - Shifts fill with 0.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Optional Feature:
- FP_NORM_COARSE_EN
  - Defined: COARSE state and norm_grp_enc are present as described.
  - Undefined: COARSE is removed; IDLE goes directly to FINE. This saves area and increases latency by up to MANT_W-1 cycles.
- Results are bit-identical either way.

Decomposition:
- Package fp_norm_pkg holds:
  - the state enum;
  - the MANT_W/EXP_W/GRP_W defaults;
  - NGRP;
  - the shift-count width, clog2(NGRP).
- Sub-module norm_grp_enc:
  - Combinational.
  - Input: NGRP all-zero flags, MSB group first.
  - Output: leading zero-group count.
  - Reused by the coarse step.

Test Plan:
- mant_in=0x000ABC, exp_in=100 → k=3, mant_out=0xABC000, exp_out=88, zero/uflow=0; out_valid 2 cycles after accept.
- mant_in=0x012345, exp_in=50 → coarse 4, fine 3, mant_out=0x91A280, exp_out=43; out_valid 5 cycles after accept. With the macro undefined: same result, 8 cycles.
- mant_in=0x000001, exp_in=5 → coarse skipped, 4 fine shifts, mant_out=0x000010, exp_out=0, uflow_out=1.
- mant_in=0, exp_in=77 → zero_out=1, exp_out=0, mant_out=0, 1-cycle latency. Also mant_in=0x400000, exp_in=0 → passthrough unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. On release, a handshake occurs and the next in_valid is accepted the following cycle.
- Reset: assert rst_n=0 during FINE → out_valid=0 and in_ready=1 immediately. After release, a fresh 0x800000/exp 10 returns unchanged in 2 cycles.
